// File: rtl/tlb_array_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tlb_params (package)                                          |
// | Brief    : Shared types, defaults and invalidate predicate for tlb_array |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package tlb_params;

  localparam int DEFAULT_TLB_NUM    = 16;
  localparam int DEFAULT_VPN2_WIDTH = 19;
  localparam int DEFAULT_ASID_WIDTH = 8;
  localparam int PFN_WIDTH          = 20;
  localparam int INDEX_WIDTH        = $clog2(DEFAULT_TLB_NUM);

  typedef struct packed {
    logic [PFN_WIDTH-1:0] pfn;
    logic [2:0]           c;
    logic                 d;
    logic                 v;
  } entry_t;

  typedef struct packed {
    logic [DEFAULT_VPN2_WIDTH-1:0] vpn2;
    logic [DEFAULT_ASID_WIDTH-1:0] asid;
    logic                          g;
    entry_t                        even_page;
    entry_t                        odd_page;
  } tlb_entry_t;

  typedef tlb_entry_t tlb_request_t;

  typedef struct packed {
    logic [DEFAULT_VPN2_WIDTH-1:0] vpn2;
    logic [DEFAULT_ASID_WIDTH-1:0] asid;
    logic                          is_odd_page;
  } search_request_t;

  typedef struct packed {
    logic                   found;
    logic [INDEX_WIDTH-1:0] index;
    entry_t                 page;
  } search_result_t;

  typedef enum logic [1:0] {
    INV_ALL            = 2'd0,
    INV_ASID           = 2'd1,
    INV_ASID_NONGLOBAL = 2'd2,
    INV_RESERVED       = 2'd3
  } inv_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } walk_state_t;

  // Reserved mode falls through to the ALL behaviour.
  function automatic logic inv_hit(input inv_mode_t                     mode,
                                   input logic [DEFAULT_ASID_WIDTH-1:0] entry_asid,
                                   input logic                          entry_g,
                                   input logic [DEFAULT_ASID_WIDTH-1:0] asid);
    case (mode)
      INV_ASID:           return (entry_asid == asid) || entry_g;
      INV_ASID_NONGLOBAL: return (entry_asid == asid) && !entry_g;
      default:            return 1'b1;
    endcase
  endfunction

endpackage : tlb_params
`default_nettype wire

// File: rtl/tlb_array_match_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tlb_match_port                                                |
// | Brief    : Combinational match vector + lowest-index priority encoder    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tlb_match_port
  import tlb_params::*;
#(
  parameter int TLB_NUM    = DEFAULT_TLB_NUM,
  parameter int VPN2_WIDTH = DEFAULT_VPN2_WIDTH,
  parameter int ASID_WIDTH = DEFAULT_ASID_WIDTH
) (
  input  tlb_entry_t       entries [TLB_NUM],
  input  logic [TLB_NUM-1:0] valid,
  input  search_request_t  req,
  output search_result_t   result
);

  logic [TLB_NUM-1:0] w_match;

  for (genvar i = 0; i < TLB_NUM; i++) begin : g_match
    assign w_match[i] = valid[i]
                      && (entries[i].vpn2[VPN2_WIDTH-1:0] == req.vpn2[VPN2_WIDTH-1:0])
                      && (entries[i].g
                          || (entries[i].asid[ASID_WIDTH-1:0] == req.asid[ASID_WIDTH-1:0]));
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    result = '0;
    for (int i = TLB_NUM - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        result.found = 1'b1;
        result.index = INDEX_WIDTH'(i);
        result.page  = req.is_odd_page ? entries[i].odd_page : entries[i].even_page;
      end
    end
  end

endmodule : tlb_match_port
`default_nettype wire

// File: rtl/tlb_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tlb_array                                                     |
// | Brief    : N-port registered-search TLB with sequential invalidate walk. |
// |            Optional macro TLB_STATS_EN enables per-port hit/miss counts. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tlb_array
  import tlb_params::*;
#(
  parameter int TLB_NUM    = DEFAULT_TLB_NUM,
  parameter int NUM_PORTS  = 2,
  parameter int VPN2_WIDTH = DEFAULT_VPN2_WIDTH,
  parameter int ASID_WIDTH = DEFAULT_ASID_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_PORTS-1:0]              search_valid,
  output logic                              search_ready,
  input  search_request_t [NUM_PORTS-1:0]   search_req,
  output logic [NUM_PORTS-1:0]              resp_valid,
  output search_result_t [NUM_PORTS-1:0]    resp,
  input  logic                              write_en,
  input  logic [$clog2(TLB_NUM)-1:0]        write_index,
  input  tlb_request_t                      write_data,
  input  logic [$clog2(TLB_NUM)-1:0]        read_index,
  output tlb_request_t                      read_data,
  output logic                              read_valid,
  input  logic                              inv_req,
  input  logic [1:0]                        inv_mode,
  input  logic [ASID_WIDTH-1:0]             inv_asid,
  output logic                              busy,
  output logic                              inv_done,
  output logic [NUM_PORTS-1:0][31:0]        stat_hits,
  output logic [NUM_PORTS-1:0][31:0]        stat_misses
);

  localparam int IDX_W = $clog2(TLB_NUM);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(TLB_NUM - 1);

  tlb_entry_t             r_entries [TLB_NUM];
  logic [TLB_NUM-1:0]     r_valid;
  walk_state_t            r_state;
  walk_state_t            w_state_nxt;
  logic [IDX_W-1:0]       r_counter;
  inv_mode_t              r_mode;
  logic [ASID_WIDTH-1:0]  r_inv_asid;
  logic                   w_walk_clear;
  logic                   w_write;
  logic [NUM_PORTS-1:0]   w_accept;
  search_result_t         w_result [NUM_PORTS];
  logic [NUM_PORTS-1:0]   r_resp_valid;
  search_result_t         r_resp [NUM_PORTS];

  always_comb begin
    w_state_nxt  = r_state;
    w_walk_clear = 1'b0;
    busy         = 1'b0;
    search_ready = 1'b0;
    inv_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        search_ready = 1'b1;
        if (inv_req) w_state_nxt = ST_WALK;
      end
      ST_WALK: begin
        busy         = 1'b1;
        w_walk_clear = inv_hit(r_mode, r_entries[r_counter].asid,
                               r_entries[r_counter].g, r_inv_asid);
        if (r_counter == C_LAST_IDX) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        inv_done    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A same-cycle inv_req takes priority and drops the write.
  assign w_write = write_en && (r_state == ST_IDLE) && !inv_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_counter  <= '0;
      r_valid    <= '0;
      r_mode     <= INV_ALL;
      r_inv_asid <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && inv_req) begin
        r_counter  <= '0;
        r_mode     <= inv_mode_t'(inv_mode);
        r_inv_asid <= inv_asid;
      end else if (r_state == ST_WALK && r_counter != C_LAST_IDX) begin
        r_counter <= r_counter + 1'b1;
      end
      if (w_write)      r_valid[write_index] <= 1'b1;
      if (w_walk_clear) r_valid[r_counter]   <= 1'b0;
    end
  end

  // Payload storage carries no reset; only the valid bits matter after reset.
  always_ff @(posedge clock) begin
    if (w_write) r_entries[write_index] <= write_data;
  end

  assign read_data  = r_entries[read_index];
  assign read_valid = r_valid[read_index];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    tlb_match_port #(
      .TLB_NUM    (TLB_NUM),
      .VPN2_WIDTH (VPN2_WIDTH),
      .ASID_WIDTH (ASID_WIDTH)
    ) u_match (
      .entries (r_entries),
      .valid   (r_valid),
      .req     (search_req[p]),
      .result  (w_result[p])
    );
    assign w_accept[p]   = search_valid[p] && search_ready;
    assign resp_valid[p] = r_resp_valid[p];
    assign resp[p]       = r_resp[p];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_resp[p] <= '0;
    end else begin
      r_resp_valid <= w_accept;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_resp[p] <= w_accept[p] ? w_result[p] : '0;
      end
    end
  end

`ifdef TLB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] r_hits;
  logic [NUM_PORTS-1:0][31:0] r_misses;

  // Counts land on the same edge that raises resp_valid for the port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_accept[p] && w_result[p].found && r_hits[p] != 32'hFFFF_FFFF)
          r_hits[p] <= r_hits[p] + 32'd1;
        if (w_accept[p] && !w_result[p].found && r_misses[p] != 32'hFFFF_FFFF)
          r_misses[p] <= r_misses[p] + 32'd1;
      end
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule : tlb_array
`default_nettype wire

// File: tb/tb_tlb_array.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_tlb_array                                                  |
// | Brief    : Directed self-checking bench for tlb_array (TLB_STATS_EN aware)|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_tlb_array;
  import tlb_params::*;

  localparam int N = 16;
  localparam int P = 2;

  logic                       clock = 1'b0;
  logic                       reset_n = 1'b0;
  logic [P-1:0]               search_valid = '0;
  logic                       search_ready;
  search_request_t [P-1:0]    search_req = '0;
  logic [P-1:0]               resp_valid;
  search_result_t [P-1:0]     resp;
  logic                       write_en = 1'b0;
  logic [3:0]                 write_index = '0;
  tlb_request_t               write_data = '0;
  logic [3:0]                 read_index = '0;
  tlb_request_t               read_data;
  logic                       read_valid;
  logic                       inv_req = 1'b0;
  logic [1:0]                 inv_mode = '0;
  logic [7:0]                 inv_asid = '0;
  logic                       busy;
  logic                       inv_done;
  logic [P-1:0][31:0]         stat_hits;
  logic [P-1:0][31:0]         stat_misses;

  int checks = 0;
  int errors = 0;

  tlb_array #(.TLB_NUM(N), .NUM_PORTS(P), .VPN2_WIDTH(19), .ASID_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .search_valid(search_valid), .search_ready(search_ready), .search_req(search_req),
    .resp_valid(resp_valid), .resp(resp),
    .write_en(write_en), .write_index(write_index), .write_data(write_data),
    .read_index(read_index), .read_data(read_data), .read_valid(read_valid),
    .inv_req(inv_req), .inv_mode(inv_mode), .inv_asid(inv_asid),
    .busy(busy), .inv_done(inv_done),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic tlb_request_t mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                      input logic g, input logic [19:0] even_pfn,
                                      input logic [19:0] odd_pfn);
    tlb_request_t e;
    e.vpn2 = vpn2; e.asid = asid; e.g = g;
    e.even_page = '{pfn: even_pfn, c: 3'd3, d: 1'b1, v: 1'b1};
    e.odd_page  = '{pfn: odd_pfn,  c: 3'd3, d: 1'b1, v: 1'b1};
    return e;
  endfunction

  task automatic do_write(input logic [3:0] idx, input tlb_request_t e);
    write_index = idx; write_data = e; write_en = 1'b1;
    step();
    write_en = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [18:0] vpn2, input logic [7:0] asid,
                         input logic odd);
    search_req[p].vpn2 = vpn2;
    search_req[p].asid = asid;
    search_req[p].is_odd_page = odd;
  endtask

  task automatic search(input int p, input logic [18:0] vpn2, input logic [7:0] asid,
                        input logic odd);
    set_req(p, vpn2, asid, odd);
    search_valid[p] = 1'b1;
    step();
    search_valid[p] = 1'b0;
  endtask

  initial begin : stim
    int n;
    logic seen;
    logic [N-1:0] vmask;

    // Reset state
    repeat (3) step();
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp0", 64'(resp[0]), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_inv_done", 64'(inv_done), 64'h0);
    read_index = 4'd3;
    #1;
    chk("rst_read_valid3", 64'(read_valid), 64'h0);
    reset_n = 1'b1;
    step();
    chk("idle_ready", 64'(search_ready), 64'h1);

    // Basic write + odd/even search
    do_write(4'd3, mk(19'h12345, 8'h05, 1'b0, 20'h11111, 20'hABCDE));
    chk("read_valid3", 64'(read_valid), 64'h1);
    chk("read_vpn2_3", 64'(read_data.vpn2), 64'h12345);
    search(0, 19'h12345, 8'h05, 1'b1);
    chk("hit_valid", 64'(resp_valid), 64'h1);
    chk("hit_found", 64'(resp[0].found), 64'h1);
    chk("hit_index", 64'(resp[0].index), 64'h3);
    chk("hit_odd_pfn", 64'(resp[0].page.pfn), 64'hABCDE);
    search(0, 19'h12345, 8'h05, 1'b0);
    chk("hit_even_pfn", 64'(resp[0].page.pfn), 64'h11111);
    step();
    chk("resp_valid_drop", 64'(resp_valid), 64'h0);

    // ASID mismatch, then global
    search(0, 19'h12345, 8'h06, 1'b1);
    chk("asid_miss_valid", 64'(resp_valid[0]), 64'h1);
    chk("asid_miss_resp", 64'(resp[0]), 64'h0);
    do_write(4'd3, mk(19'h12345, 8'h05, 1'b1, 20'h11111, 20'hABCDE));
    search(0, 19'h12345, 8'h06, 1'b1);
    chk("global_found", 64'(resp[0].found), 64'h1);

    // Duplicates on 2 and 7, both ports together
    do_write(4'd7, mk(19'h00777, 8'h09, 1'b0, 20'h33333, 20'h22222));
    do_write(4'd2, mk(19'h00777, 8'h09, 1'b0, 20'h33333, 20'h22222));
    set_req(0, 19'h00777, 8'h09, 1'b1);
    set_req(1, 19'h00777, 8'h09, 1'b1);
    search_valid = 2'b11;
    step();
    search_valid = 2'b00;
    chk("dual_valid", 64'(resp_valid), 64'h3);
    chk("dup_index_p0", 64'(resp[0].index), 64'h2);
    chk("dup_index_p1", 64'(resp[1].index), 64'h2);
    chk("dup_pfn_p1", 64'(resp[1].page.pfn), 64'h22222);
    chk("dup_ports_eq", 64'(resp[1]), 64'(resp[0]) ^ 64'h0);

    // Write and search in the same cycle
    set_req(0, 19'h04444, 8'h01, 1'b0);
    write_index = 4'd4; write_data = mk(19'h04444, 8'h01, 1'b0, 20'h44444, 20'h55555);
    write_en = 1'b1; search_valid[0] = 1'b1;
    step();
    write_en = 1'b0; search_valid[0] = 1'b0;
    chk("same_cycle_miss", 64'(resp[0].found), 64'h0);
    search(0, 19'h04444, 8'h01, 1'b0);
    chk("next_cycle_hit", 64'(resp[0].found), 64'h1);
    chk("next_cycle_idx", 64'(resp[0].index), 64'h4);
    chk("next_cycle_pfn", 64'(resp[0].page.pfn), 64'h44444);

    // Fill table and walk with ASID_NONGLOBAL / asid 0x01
    for (int i = 0; i < N; i++)
      do_write(4'(i), mk(19'(32'h100 + i), (i % 2 == 0) ? 8'h01 : 8'h02, (i == 0),
                         20'(i), 20'(32'h100 + i)));
    inv_mode = 2'd2; inv_asid = 8'h01; inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    chk("walk_busy", 64'(busy), 64'h1);
    chk("walk_ready", 64'(search_ready), 64'h0);
    // Writes and searches presented during the walk must be ignored
    write_index = 4'd3; write_data = mk(19'h7FFFF, 8'h02, 1'b0, 20'h0, 20'h0); write_en = 1'b1;
    set_req(1, 19'h101, 8'h02, 1'b1); search_valid[1] = 1'b1;
    n = 0; seen = 1'b0;
    while (!inv_done && n < 40) begin
      step();
      n++;
      if (search_ready || resp_valid != '0) seen = 1'b1;
    end
    write_en = 1'b0; search_valid[1] = 1'b0;
    chk("walk_len", 64'(n), 64'(N));
    chk("walk_done_pulse", 64'(inv_done), 64'h1);
    chk("walk_no_ready", 64'(seen), 64'h0);
    step();
    chk("done_drop", 64'(inv_done), 64'h0);
    chk("done_idle", 64'(busy), 64'h0);
    for (int i = 0; i < N; i++) begin
      read_index = 4'(i);
      #1;
      chk($sformatf("walk_valid%0d", i), 64'(read_valid), 64'((i == 0) || (i % 2 == 1)));
    end
    read_index = 4'd3;
    #1;
    chk("walk_write_dropped", 64'(read_data.vpn2), 64'h103);

    // Reset during walk (ALL)
    inv_mode = 2'd0; inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    chk("rst_walk_busy", 64'(busy), 64'h0);
    chk("rst_walk_done", 64'(inv_done), 64'h0);
    chk("rst_walk_ready", 64'(search_ready), 64'h1);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      read_index = 4'(i);
      #1;
      vmask[i] = read_valid;
    end
    chk("rst_walk_valids", 64'(vmask), 64'h0);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (inv_done || busy) seen = 1'b1;
    end
    chk("rst_walk_no_done", 64'(seen), 64'h0);

    // Statistics on port 1: 3 hits, 2 misses
    do_write(4'd5, mk(19'h05555, 8'h03, 1'b0, 20'h5A5A5, 20'hA5A5A));
    search(1, 19'h05555, 8'h03, 1'b0);
    chk("stat_hit_found", 64'(resp[1].found), 64'h1);
    search(1, 19'h06666, 8'h03, 1'b0);
    search(1, 19'h05555, 8'h03, 1'b1);
    search(1, 19'h05555, 8'h04, 1'b1);
    chk("stat_miss_found", 64'(resp[1].found), 64'h0);
    search(1, 19'h05555, 8'h03, 1'b0);
`ifdef TLB_STATS_EN
    chk("stat_hits1", 64'(stat_hits[1]), 64'd3);
    chk("stat_misses1", 64'(stat_misses[1]), 64'd2);
    chk("stat_hits0", 64'(stat_hits[0]), 64'd0);
`else
    chk("stat_hits_tied", 64'(stat_hits), 64'd0);
    chk("stat_misses_tied", 64'(stat_misses), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tlb_array
`default_nettype wire
